parser_cfg_sequencer: RTL and testbench

- Control-path sequencer that owns the write port of the parser action RAM.
- Filters the control AXIS stream and consumes config packets addressed to this parser (mod ID plus control flag).
- Freezes datapath lookups via a busy/idle handshake, then burst-writes entries at consecutive addresses.
- Forwards all other control packets downstream unchanged, with back-pressure.

---
 rtl/parser_cfg_pkg.sv | 23 ++
 rtl/parser_cfg_sequencer_if.sv | 16 +
 rtl/parser_cfg_sequencer_out_reg.sv | 44 ++++
 rtl/parser_cfg_sequencer.sv | 171 +++++++++++++++++
 tb/tb_parser_cfg_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_cfg_pkg.sv
// Shared FSM state, control-header field layout and entry byte-swap for the parser config sequencer.
// Entries sit byte-reversed in the low 20 bytes of each entry beat.
package parser_cfg_pkg;

  typedef enum logic [2:0] {IDLE, FWD, DRAIN, WRITE, DROP} state_e;

  localparam int MOD_ID_LSB = 368;
  localparam int FLAG_LSB   = 320;
  localparam int INDEX_LSB  = 384;

  localparam logic [15:0] DEF_CTRL_FLAG = 16'hf2f1;
  localparam int          ENTRY_W       = 160;

  function automatic logic [ENTRY_W-1:0] entry_swap(input logic [ENTRY_W-1:0] d);
    logic [ENTRY_W-1:0] e;
    e = '0;
    for (int k = 0; k < ENTRY_W/8; k++) begin
      e[ENTRY_W-1-8*k -: 8] = d[8*k +: 8];
    end
    return e;
  endfunction

endpackage

// File: rtl/parser_cfg_sequencer_if.sv
// AXI-stream bundle for the control path; master drives beats, slave returns tready.
// Used for both the inbound and the forwarded control streams.
interface parser_cfg_sequencer_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
) ();
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tuser, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/parser_cfg_sequencer_out_reg.sv
// Single-entry registered stage for forwarded control beats: 1-cycle latency, holds while out_rdy=0,
// and accepts a new beat in the same cycle the held one drains (in_rdy = empty or draining).
module ctrl_axis_out_reg #(
  parameter type T = logic
) (
  input  logic axis_clk,
  input  logic areset,
  input  logic in_vld,
  output logic in_rdy,
  input  T     in_dat,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_dat
);

  logic vld_q, vld_d;
  T     dat_q, dat_d;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/parser_cfg_sequencer.sv
// Consumes matching config packets into the action RAM (busy/idle freeze, burst writes), forwards the rest
// through a 1-cycle output register with back-pressure. PARSER_CFG_ERR_CNT_EN adds cfg_err_cnt.
module parser_cfg_sequencer
  import parser_cfg_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [2:0]  PARSER_MOD_ID        = 3'b000,
  parameter logic [15:0] CTRL_FLAG            = DEF_CTRL_FLAG,
  parameter int          C_PARSER_RAM_WIDTH   = ENTRY_W,
  parameter int          C_RAM_ADDR_WIDTH     = 5
) (
  input  logic                          axis_clk,
  input  logic                          areset,
  parser_cfg_sequencer_if.slave         ctrl_s_axis,
  parser_cfg_sequencer_if.master        ctrl_m_axis,
  output logic                          ram_wen,
  output logic [C_RAM_ADDR_WIDTH-1:0]   ram_waddr,
  output logic [C_PARSER_RAM_WIDTH-1:0] ram_wdata,
  output logic                          cfg_busy,
  input  logic                          lookup_idle,
  output logic [15:0]                   cfg_pkt_cnt
`ifdef PARSER_CFG_ERR_CNT_EN
  ,
  output logic [7:0]                    cfg_err_cnt
`endif
);

  localparam int AW = C_RAM_ADDR_WIDTH;

  typedef struct packed {
    logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic                             tlast;
  } beat_t;

  state_e                        state_q, state_d;
  logic [AW:0]                   nxt_q, nxt_d;   // base+n with a carry bit marking overflow
  logic                          ram_wen_q, ram_wen_d;
  logic [AW-1:0]                 ram_waddr_q, ram_waddr_d;
  logic [C_PARSER_RAM_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                          cfg_busy_q, cfg_busy_d;
  logic [15:0]                   pkt_cnt_q, pkt_cnt_d;

  logic  s_rdy, fwd_rdy, fwd_push, acc, hdr_match;
  beat_t in_beat, out_beat;

  assign hdr_match = (ctrl_s_axis.tdata[MOD_ID_LSB +: 3] == PARSER_MOD_ID) &&
                     (ctrl_s_axis.tdata[FLAG_LSB +: 16] == CTRL_FLAG);

  always_comb begin
    s_rdy = 1'b1;
    case (state_q)
      IDLE, FWD: s_rdy = fwd_rdy;
      DRAIN:     s_rdy = 1'b0;
      default:   s_rdy = 1'b1;
    endcase
  end

  assign ctrl_s_axis.tready = s_rdy && !areset;
  assign acc      = ctrl_s_axis.tvalid && s_rdy;
  assign fwd_push = acc && ((state_q == FWD) || ((state_q == IDLE) && !hdr_match));

  assign in_beat = '{tdata: ctrl_s_axis.tdata, tuser: ctrl_s_axis.tuser,
                     tkeep: ctrl_s_axis.tkeep, tlast: ctrl_s_axis.tlast};

  ctrl_axis_out_reg #(.T(beat_t)) u_out_reg (
    .axis_clk (axis_clk),
    .areset   (areset),
    .in_vld   (fwd_push),
    .in_rdy   (fwd_rdy),
    .in_dat   (in_beat),
    .out_vld  (ctrl_m_axis.tvalid),
    .out_rdy  (ctrl_m_axis.tready),
    .out_dat  (out_beat)
  );

  assign ctrl_m_axis.tdata = out_beat.tdata;
  assign ctrl_m_axis.tuser = out_beat.tuser;
  assign ctrl_m_axis.tkeep = out_beat.tkeep;
  assign ctrl_m_axis.tlast = out_beat.tlast;

  always_comb begin
    state_d     = state_q;
    nxt_d       = nxt_q;
    ram_wen_d   = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    pkt_cnt_d   = pkt_cnt_q;
    case (state_q)
      IDLE: if (acc) begin
        if (!hdr_match) begin
          if (!ctrl_s_axis.tlast) state_d = FWD;
        end else if (ctrl_s_axis.tlast) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
          nxt_d   = {1'b0, ctrl_s_axis.tdata[INDEX_LSB +: AW]};
          state_d = DRAIN;
        end
      end
      FWD:   if (acc && ctrl_s_axis.tlast) state_d = IDLE;
      DRAIN: if (lookup_idle && cfg_busy_q) state_d = WRITE;
      WRITE: if (acc) begin
        if (nxt_q[AW]) begin
          // An overflowing last beat has nothing left to drain.
          state_d = ctrl_s_axis.tlast ? IDLE : DROP;
        end else begin
          ram_wen_d   = 1'b1;
          ram_waddr_d = nxt_q[AW-1:0];
          ram_wdata_d = entry_swap(ctrl_s_axis.tdata[C_PARSER_RAM_WIDTH-1:0]);
          nxt_d       = nxt_q + 1'b1;
          if (ctrl_s_axis.tlast) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
        end
      end
      DROP:    if (acc && ctrl_s_axis.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Busy covers the final write pulse so no lookup races the last RAM update.
    cfg_busy_d = (state_d inside {DRAIN, WRITE, DROP}) || ram_wen_d;
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      nxt_q       <= '0;
      ram_wen_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      cfg_busy_q  <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      ram_wen_q   <= ram_wen_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      cfg_busy_q  <= cfg_busy_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign ram_wen     = ram_wen_q;
  assign ram_waddr   = ram_waddr_q;
  assign ram_wdata   = ram_wdata_q;
  assign cfg_busy    = cfg_busy_q;
  assign cfg_pkt_cnt = pkt_cnt_q;

`ifdef PARSER_CFG_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       drop_evt;

  assign drop_evt = (state_q == WRITE) && acc && nxt_q[AW];

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop_evt && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign cfg_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parser_cfg_sequencer.sv
// Directed bench for parser_cfg_sequencer: packet-level model of forwards, RAM writes and counters,
// checked every cycle by one compare process plus hand-computed literal expectations.
module tb_parser_cfg_sequencer;

  typedef struct packed {
    logic [511:0] data;
    logic [127:0] user;
    logic [63:0]  keep;
    logic         last;
  } tbeat_t;

  typedef struct packed {
    logic [4:0]   a;
    logic [159:0] d;
  } wr_t;

  logic         clk, rst, lookup_idle;
  logic         ram_wen, cfg_busy;
  logic [4:0]   ram_waddr;
  logic [159:0] ram_wdata;
  logic [15:0]  pkt_cnt;
`ifdef PARSER_CFG_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  parser_cfg_sequencer_if s_if ();
  parser_cfg_sequencer_if m_if ();

  parser_cfg_sequencer dut (
    .axis_clk    (clk),
    .areset      (rst),
    .ctrl_s_axis (s_if),
    .ctrl_m_axis (m_if),
    .ram_wen     (ram_wen),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .cfg_busy    (cfg_busy),
    .lookup_idle (lookup_idle),
    .cfg_pkt_cnt (pkt_cnt)
`ifdef PARSER_CFG_ERR_CNT_EN
    ,
    .cfg_err_cnt (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_cmp = 0;
  int     n_err = 0;
  tbeat_t tx[$];
  tbeat_t exp_fwd[$];
  wr_t    exp_wr[$];
  wr_t    wr_log[$];
  int     exp_pkt = 0;
  int     exp_err = 0;
  logic   busy_seen = 1'b0;
  tbeat_t cmp_beat;
  wr_t    cmp_wr;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [159:0] swap_ref(input logic [511:0] d);
    logic [159:0] e;
    e = '0;
    for (int k = 0; k < 20; k++) e[8*(19-k) +: 8] = d[8*k +: 8];
    return e;
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [2:0] mod, input logic [15:0] flag, input logic [7:0] idx);
    logic [511:0] d;
    d = '0;
    d[63:0]    = 64'hdead_beef_0000_0001;
    d[370:368] = mod;
    d[335:320] = flag;
    d[391:384] = idx;
    return d;
  endfunction

  function automatic logic [511:0] mk_ent(input logic [31:0] seed);
    logic [511:0] d;
    d = '0;
    d[159:0] = {seed ^ 32'h1111_1111, seed + 32'd7, ~seed, seed << 3, seed};
    return d;
  endfunction

  task automatic add(input logic [511:0] d, input logic last);
    tbeat_t b;
    b.data = d;
    b.user = {4{d[31:0]}} ^ 128'h5a;
    b.keep = 64'hffff_ffff_ffff_ffff;
    b.last = last;
    tx.push_back(b);
  endtask

  // Packet-level expectation: where each beat must end up, by the header rules.
  task automatic model_pkt();
    logic [511:0] h;
    int           base;
    logic         dropped;
    wr_t          w;
    h = tx[0].data;
    if (h[370:368] == 3'd0 && h[335:320] == 16'hf2f1) begin
      base    = int'(h[388:384]);
      dropped = 1'b0;
      for (int n = 1; n < tx.size(); n++) begin
        if (base + n - 1 > 31) begin
          dropped = 1'b1;
          break;
        end
        w.a = 5'(base + n - 1);
        w.d = swap_ref(tx[n].data);
        exp_wr.push_back(w);
      end
      if (dropped) exp_err++;
      else         exp_pkt++;
    end else begin
      foreach (tx[i]) exp_fwd.push_back(tx[i]);
    end
  endtask

  task automatic send_beat(input tbeat_t b);
    logic rdy;
    s_if.tdata  = b.data;
    s_if.tuser  = b.user;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tvalid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      if (c >= 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", c);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic run_pkt();
    model_pkt();
    foreach (tx[i]) send_beat(tx[i]);
  endtask

  task automatic check_idle(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    chk({tag, "_busy"}, cfg_busy, 0);
    chk({tag, "_fwd_left"}, exp_fwd.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
`ifdef PARSER_CFG_ERR_CNT_EN
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
`endif
    @(posedge clk);
    #1;
  endtask

  // Compare process: every forwarded handshake and every RAM write against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_busy) busy_seen = 1'b1;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_fwd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL fwd_unexpected: got beat %h last %b, required no beat", m_if.tdata[31:0], m_if.tlast);
        end else begin
          cmp_beat = exp_fwd.pop_front();
          chk("fwd_data", m_if.tdata[159:0], cmp_beat.data[159:0]);
          chk("fwd_hdr", m_if.tdata[511:352], cmp_beat.data[511:352]);
          chk("fwd_user_keep_last", {m_if.tuser[94:0], m_if.tkeep, m_if.tlast},
              {cmp_beat.user[94:0], cmp_beat.keep, cmp_beat.last});
        end
      end
      if (ram_wen) begin
        cmp_wr.a = ram_waddr;
        cmp_wr.d = ram_wdata;
        wr_log.push_back(cmp_wr);
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_unexpected: got write addr %0d, required no write", ram_waddr);
        end else begin
          cmp_wr = exp_wr.pop_front();
          chk("wr_addr", ram_waddr, cmp_wr.a);
          chk("wr_data", ram_wdata, cmp_wr.d);
        end
      end
    end
  end

  logic done;

  initial begin
    rst         = 1'b1;
    lookup_idle = 1'b1;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    #12;
    chk("rst_wen", ram_wen, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s_tready", s_if.tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-matching (mod id 1, correct flag): forwarded, one-cycle latency.
    busy_seen = 1'b0;
    tx.delete();
    add(mk_hdr(3'd1, 16'hf2f1, 8'd5), 1'b0);
    add(mk_ent(32'h1000), 1'b0);
    add(mk_ent(32'h2000), 1'b1);
    model_pkt();
    send_beat(tx[0]);
    chk("fwd_latency_vld", m_if.tvalid, 1);
    chk("fwd_latency_dat", m_if.tdata[159:0], tx[0].data[159:0]);
    send_beat(tx[1]);
    send_beat(tx[2]);
    check_idle("t1");
    chk("t1_busy_never", busy_seen, 0);

    // Config, index 0xE4 -> base 4 (upper bits ignored), three entries.
    wr_log.delete();
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'he4), 1'b0);
    add({480'h0, 32'h0403_0201}, 1'b0);
    add(mk_ent(32'h0a0b_0c0d), 1'b0);
    add(mk_ent(32'h5555_aaaa), 1'b1);
    model_pkt();
    send_beat(tx[0]);
    chk("t2_busy_rise", cfg_busy, 1);
    send_beat(tx[1]);
    send_beat(tx[2]);
    send_beat(tx[3]);
    chk("t2_last_wen", ram_wen, 1);
    chk("t2_last_addr", ram_waddr, 6);
    chk("t2_busy_at_last", cfg_busy, 1);
    @(posedge clk);
    #1;
    chk("t2_busy_fall", cfg_busy, 0);
    chk("t2_wen_fall", ram_wen, 0);
    check_idle("t2");
    chk("t2_pkt_lit", pkt_cnt, 1);
    chk("t2_wr_count", wr_log.size(), 3);
    if (wr_log.size() >= 3) begin
      chk("t2_addr0_lit", wr_log[0].a, 4);
      chk("t2_data0_lit", wr_log[0].d, 160'h0102030400000000000000000000000000000000);
      chk("t2_addr1_lit", wr_log[1].a, 5);
    end

    // Same shape with lookup_idle held low for 10 cycles: no accepts, no writes.
    lookup_idle = 1'b0;
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'd4), 1'b0);
    add(mk_ent(32'h3333_0001), 1'b0);
    add(mk_ent(32'h3333_0002), 1'b0);
    add(mk_ent(32'h3333_0003), 1'b1);
    fork
      run_pkt();
      begin
        for (int c = 0; c < 50 && !cfg_busy; c++) @(negedge clk);
        chk("t3_busy_up", cfg_busy, 1);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("t3_hold_tready", s_if.tready, 0);
          chk("t3_hold_wen", ram_wen, 0);
        end
        @(posedge clk);
        #1;
        lookup_idle = 1'b1;
      end
    join
    check_idle("t3");
    chk("t3_pkt_lit", pkt_cnt, 2);

    // Base 30 with four entries: writes at 30, 31 only, rest dropped.
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'd30), 1'b0);
    for (int i = 0; i < 4; i++) add(mk_ent(32'h4400 + i), i == 3);
    run_pkt();
    check_idle("t4");
    chk("t4_pkt_lit", pkt_cnt, 2);
`ifdef PARSER_CFG_ERR_CNT_EN
    chk("t4_err_lit", err_cnt, 1);
`endif

    // Empty config (header with tlast): counted, busy never raised.
    busy_seen = 1'b0;
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'd9), 1'b1);
    run_pkt();
    check_idle("t4b");
    chk("t4b_busy_never", busy_seen, 0);
    chk("t4b_pkt_lit", pkt_cnt, 3);

    // Forwarded packet (wrong flag) with downstream ready toggling.
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f0, 8'd3), 1'b0);
    for (int i = 0; i < 5; i++) add(mk_ent(32'h7700 + i), i == 4);
    done = 1'b0;
    fork
      begin
        run_pkt();
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        m_if.tready = ~m_if.tready;
      end
      while (!done) begin
        @(negedge clk);
        chk("t5_tready_rule", s_if.tready, !m_if.tvalid || m_if.tready);
      end
    join
    m_if.tready = 1'b1;
    check_idle("t5");

    // Reset in the middle of WRITE while the 2nd entry is presented.
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'd8), 1'b0);
    add(mk_ent(32'h8800), 1'b0);
    exp_wr.push_back('{a: 5'd8, d: swap_ref(tx[1].data)});
    send_beat(tx[0]);
    send_beat(tx[1]);
    s_if.tdata  = mk_ent(32'h8801);
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_wen", ram_wen, 0);
    chk("t6_rst_waddr", ram_waddr, 0);
    chk("t6_rst_wdata", ram_wdata, 0);
    chk("t6_rst_busy", cfg_busy, 0);
    chk("t6_rst_pkt", pkt_cnt, 0);
    chk("t6_rst_m_tvalid", m_if.tvalid, 0);
    chk("t6_rst_s_tready", s_if.tready, 0);
    s_if.tvalid = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx.delete();
    add(mk_ent(32'h8802), 1'b1);
    run_pkt();
    tx.delete();
    add(mk_hdr(3'd0, 16'hf2f1, 8'd0), 1'b0);
    add(mk_ent(32'h9900), 1'b1);
    run_pkt();
    check_idle("t6");
    chk("t6_pkt_lit", pkt_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
